// File: rtl/ips2l_uart_cmd_seq_32bit.sv
// Purpose: parse framed UART byte commands into single 32-bit register bank
//          transactions and return an ACK, NAK or 4 read-data bytes.
// Ports:   rx_* UART receive strobe/byte; tx_* UART transmit valid/ready;
//          cmd_* bank command port; fifo_data* bank read data;
//          busy/err_pulse/err_code status.
// Latency: last frame byte -> cmd_en 1 cycle; cmd_done -> tx_valid 1 cycle.
// Backpressure: tx_valid held with stable tx_data until tx_ready; rx bytes
//          arriving while a command is in flight are dropped.
module ips2l_uart_cmd_seq_32bit #(
    parameter logic [7:0]  OP_WRITE    = 8'h57,
    parameter logic [7:0]  OP_READ     = 8'h52,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15,
    parameter int unsigned RX_TIMEOUT  = 50000,
    parameter int unsigned CMD_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic        cmd_we,
    output logic        cmd_en,
    input  logic        cmd_done,
    input  logic [31:0] fifo_data,
    output logic        fifo_data_valid,
    input  logic        fifo_data_req,
    output logic        busy,
    output logic        err_pulse,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, ISSUE, WAIT, TX_ACK, TX_RD, TX_NAK
    } state_t;

    // rx_cnt_q counts idle cycles since the last accepted byte (0-based), so
    // the frame is abandoned on the RX_TIMEOUT-th silent cycle.
    localparam logic [19:0] RX_LAST = 20'(RX_TIMEOUT - 1);
    // cmd_cnt_q equals the number of cycles elapsed since cmd_en.
    localparam logic [15:0] CMD_LIM = 16'(CMD_TIMEOUT);

    state_t      state_q;
    logic        we_q;
    logic [7:0]  addr_q;
    logic [31:0] data_q;
    logic        cmd_en_q;
    logic [1:0]  byte_cnt_q;
    logic [19:0] rx_cnt_q;
    logic [15:0] cmd_cnt_q;
    logic [31:0] sh_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        err_pulse_q;
    logic [1:0]  err_code_q;

    // Read data is captured on cmd_done alone; the bank strobe is monitor-only.
    logic unused_fifo_req;
    assign unused_fifo_req = fifo_data_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= 8'h00;
            data_q      <= 32'h0;
            cmd_en_q    <= 1'b0;
            byte_cnt_q  <= 2'd0;
            rx_cnt_q    <= 20'd0;
            cmd_cnt_q   <= 16'd0;
            sh_q        <= 32'h0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            err_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    rx_cnt_q <= 20'd0;
                    if (rx_valid) begin
                        if (rx_data == OP_WRITE) begin
                            we_q    <= 1'b1;
                            state_q <= ADDR;
                        end else if (rx_data == OP_READ) begin
                            we_q    <= 1'b0;
                            state_q <= ADDR;
                        end else begin
                            err_pulse_q <= 1'b1;
                            err_code_q  <= 2'd1;
                        end
                    end
                end
                ADDR, DATA: begin
                    // A byte landing on the timeout cycle is still accepted.
                    if (rx_valid) begin
                        rx_cnt_q <= 20'd0;
                        if (state_q == ADDR) begin
                            addr_q     <= rx_data;
                            byte_cnt_q <= 2'd0;
                            if (we_q) begin
                                state_q <= DATA;
                            end else begin
                                state_q  <= ISSUE;
                                cmd_en_q <= 1'b1;
                            end
                        end else begin
                            data_q     <= {data_q[23:0], rx_data};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                state_q  <= ISSUE;
                                cmd_en_q <= 1'b1;
                            end
                        end
                    end else if (rx_cnt_q == RX_LAST) begin
                        state_q     <= IDLE;
                        err_pulse_q <= 1'b1;
                        err_code_q  <= 2'd2;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 20'd1;
                    end
                end
                ISSUE: begin
                    cmd_en_q  <= 1'b0;
                    cmd_cnt_q <= 16'd1;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    // cmd_done takes priority over a simultaneous timeout.
                    if (cmd_done) begin
                        tx_valid_q <= 1'b1;
                        if (we_q) begin
                            tx_data_q <= ACK_BYTE;
                            state_q   <= TX_ACK;
                        end else begin
                            sh_q       <= fifo_data;
                            tx_data_q  <= fifo_data[31:24];
                            byte_cnt_q <= 2'd0;
                            state_q    <= TX_RD;
                        end
                    end else if (cmd_cnt_q == CMD_LIM) begin
                        tx_valid_q  <= 1'b1;
                        tx_data_q   <= NAK_BYTE;
                        state_q     <= TX_NAK;
                        err_pulse_q <= 1'b1;
                        err_code_q  <= 2'd3;
                    end else begin
                        cmd_cnt_q <= cmd_cnt_q + 16'd1;
                    end
                end
                TX_ACK, TX_NAK: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                TX_RD: begin
                    if (tx_ready) begin
                        if (byte_cnt_q == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            sh_q       <= {sh_q[23:0], 8'h00};
                            tx_data_q  <= sh_q[23:16];
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data         = tx_data_q;
    assign tx_valid        = tx_valid_q;
    assign cmd_addr        = addr_q;
    assign cmd_data        = data_q;
    assign cmd_we          = we_q;
    assign cmd_en          = cmd_en_q;
    assign fifo_data_valid = (state_q == WAIT) && !we_q;
    assign busy            = (state_q != IDLE);
    assign err_pulse       = err_pulse_q;
    assign err_code        = err_code_q;

endmodule

// File: tb/tb_ips2l_uart_cmd_seq_32bit.sv
module tb_ips2l_uart_cmd_seq_32bit;

    localparam int RXTO  = 20;
    localparam int CMDTO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_we;
    logic        cmd_en;
    logic        cmd_done;
    logic [31:0] fifo_data;
    logic        fifo_data_valid;
    logic        fifo_data_req;
    logic        busy;
    logic        err_pulse;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;
    int en_cnt = 0;
    int err_cnt = 0;
    int en_base;
    int err_base;
    int lat;
    logic [7:0] txq[$];
    logic       stall_q = 1'b0;
    logic [7:0] stall_dat = 8'h00;

    always #5 clk = ~clk;

    ips2l_uart_cmd_seq_32bit #(
        .RX_TIMEOUT (RXTO),
        .CMD_TIMEOUT(CMDTO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .cmd_we         (cmd_we),
        .cmd_en         (cmd_en),
        .cmd_done       (cmd_done),
        .fifo_data      (fifo_data),
        .fifo_data_valid(fifo_data_valid),
        .fifo_data_req  (fifo_data_req),
        .busy           (busy),
        .err_pulse      (err_pulse),
        .err_code       (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change #1 after posedge, so negedge sees the values the next
    // posedge will act on.
    always @(negedge clk) begin
        if (cmd_en) en_cnt++;
        if (err_pulse) err_cnt++;
        if (stall_q && tx_valid) chk("tx_stable", {24'h0, tx_data}, {24'h0, stall_dat});
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        stall_q   = tx_valid && !tx_ready;
        stall_dat = tx_data;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // Returns the number of negedges until cmd_en is seen (0 on expiry).
    task automatic wait_en(output int n);
        n = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (cmd_en) begin
                n = c;
                break;
            end
        end
    endtask

    // Called at the negedge of the cmd_en cycle; cmd_done lands k cycles later.
    task automatic bank_done(input int k, input logic [31:0] d);
        repeat (k) @(posedge clk);
        #1;
        fifo_data = d;
        cmd_done  = 1'b1;
        @(posedge clk); #1;
        cmd_done  = 1'b0;
        fifo_data = 32'hDEADBEEF;
    endtask

    task automatic wait_tx(input int n);
        for (int c = 0; c < 200 && txq.size() < n; c++) @(negedge clk);
        chk("tx_count", txq.size(), n);
    endtask

    task automatic check_word(input string tag, input logic [31:0] w);
        wait_tx(4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_b%0d", tag, i), {24'h0, txq[i]}, {24'h0, w[31-8*i -: 8]});
    endtask

    initial begin
        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        cmd_done = 1'b0; fifo_data = 32'hDEADBEEF; fifo_data_req = 1'b0;
        #1;
        chk("rst_tx_valid", {31'h0, tx_valid}, 0);
        chk("rst_tx_data", {24'h0, tx_data}, 0);
        chk("rst_cmd_en", {31'h0, cmd_en}, 0);
        chk("rst_cmd_data", cmd_data, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_err_code", {30'h0, err_code}, 0);
        chk("rst_fdv", {31'h0, fifo_data_valid}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Write frame, done 4 cycles after cmd_en, ACK back.
        txq.delete(); en_base = en_cnt;
        send_byte(8'h57); send_byte(8'h03); send_byte(8'h12);
        send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        wait_en(lat);
        chk("wr_en_lat", lat, 1);
        chk("wr_addr", {24'h0, cmd_addr}, 32'h03);
        chk("wr_data", cmd_data, 32'h12345678);
        chk("wr_we", {31'h0, cmd_we}, 1);
        bank_done(4, 32'h0);
        @(negedge clk);
        chk("wr_ack_lat", {31'h0, tx_valid}, 1);
        wait_tx(1);
        chk("wr_ack", {24'h0, txq[0]}, 32'h06);
        chk("wr_en_pulses", en_cnt - en_base, 1);
        @(negedge clk);
        chk("wr_idle", {31'h0, busy}, 0);

        // Read frame with random tx_ready stalls.
        txq.delete();
        send_byte(8'h52); send_byte(8'hFF);
        wait_en(lat);
        chk("rd_en_lat", lat, 1);
        chk("rd_we", {31'h0, cmd_we}, 0);
        chk("rd_addr", {24'h0, cmd_addr}, 32'hFF);
        @(negedge clk);
        chk("rd_fdv", {31'h0, fifo_data_valid}, 1);
        tx_ready = 1'b0;
        bank_done(2, 32'h20200729);
        for (int c = 0; c < 200 && txq.size() < 4; c++) begin
            @(posedge clk); #1;
            tx_ready = 1'($urandom_range(0, 1));
        end
        tx_ready = 1'b1;
        check_word("rd", 32'h20200729);
        chk("rd_err_code", {30'h0, err_code}, 0);

        // Bad opcode, then a normal read.
        txq.delete(); err_base = err_cnt;
        send_byte(8'h41);
        @(negedge clk);
        chk("bad_pulse", {31'h0, err_pulse}, 1);
        chk("bad_code", {30'h0, err_code}, 1);
        chk("bad_busy", {31'h0, busy}, 0);
        send_byte(8'h52); send_byte(8'h07);
        wait_en(lat);
        bank_done(1, 32'h0BADF00D);
        check_word("bad_next", 32'h0BADF00D);
        chk("bad_err_pulses", err_cnt - err_base, 1);

        // Inter-byte timeout mid-frame.
        txq.delete(); en_base = en_cnt; err_base = err_cnt;
        send_byte(8'h57); send_byte(8'h05); send_byte(8'hAA);
        repeat (RXTO + 5) @(negedge clk);
        chk("rxto_code", {30'h0, err_code}, 2);
        chk("rxto_busy", {31'h0, busy}, 0);
        chk("rxto_no_en", en_cnt - en_base, 0);
        chk("rxto_no_tx", txq.size(), 0);
        chk("rxto_pulses", err_cnt - err_base, 1);
        send_byte(8'h52); send_byte(8'h05);
        wait_en(lat);
        chk("rxto_next_addr", {24'h0, cmd_addr}, 32'h05);
        bank_done(3, 32'hA5A55A5A);
        check_word("rxto_next", 32'hA5A55A5A);

        // Command timeout: no done, NAK decided on cycle 16 after cmd_en.
        txq.delete();
        send_byte(8'h52); send_byte(8'h11);
        wait_en(lat);
        repeat (CMDTO) @(posedge clk);
        @(negedge clk);
        chk("cto_wait16", {31'h0, tx_valid}, 0);
        chk("cto_fdv16", {31'h0, fifo_data_valid}, 1);
        @(negedge clk);
        chk("cto_nak_vld", {31'h0, tx_valid}, 1);
        chk("cto_nak_dat", {24'h0, tx_data}, 32'h15);
        chk("cto_pulse", {31'h0, err_pulse}, 1);
        chk("cto_code", {30'h0, err_code}, 3);
        wait_tx(1);
        chk("cto_nak_q", {24'h0, txq[0]}, 32'h15);

        // cmd_done exactly on cycle 16 wins over the timeout.
        txq.delete(); err_base = err_cnt;
        send_byte(8'h52); send_byte(8'h12);
        wait_en(lat);
        bank_done(CMDTO, 32'hCAFE0016);
        check_word("cto_tie", 32'hCAFE0016);
        chk("cto_tie_pulses", err_cnt - err_base, 0);
        chk("cto_tie_sticky", {30'h0, err_code}, 3);

        // Reset while the second read byte is on the wire.
        txq.delete();
        send_byte(8'h52); send_byte(8'h13);
        wait_en(lat);
        tx_ready = 1'b0;
        bank_done(1, 32'hA1B2C3D4);
        @(posedge clk); #1 tx_ready = 1'b1;
        @(posedge clk); #1 tx_ready = 1'b0;
        @(negedge clk);
        chk("rst_mid_b2", {24'h0, tx_data}, 32'hB2);
        chk("rst_mid_cnt", txq.size(), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", {31'h0, tx_valid}, 0);
        chk("rst_mid_busy", {31'h0, busy}, 0);
        chk("rst_mid_code", {30'h0, err_code}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; tx_ready = 1'b1;
        txq.delete(); en_base = en_cnt;
        send_byte(8'h57); send_byte(8'h21); send_byte(8'hDE);
        send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_en(lat);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_addr", {24'h0, cmd_addr}, 32'h21);
        chk("post_rst_data", cmd_data, 32'hDEADBEEF);
        bank_done(2, 32'h0);
        wait_tx(1);
        chk("post_rst_ack", {24'h0, txq[0]}, 32'h06);
        chk("post_rst_en", en_cnt - en_base, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
